data_memory_be: RTL
===================

# data_memory_be

Byte-addressable, parametrised data memory for the MEM stage of the MIPS pipeline CPU, supporting lb/lbu/lh/lhu/lw/sb/sh/sw. It adds a sequential clear sweep after reset with a `busy` stall, and alignment/range fault detection with a sticky fault record. The block sits between the EX/MEM pipeline register and the MEM/WB writeback mux. `busy` drives the hazard unit's stall input.

## Interface
- `RAM_SIZE`, 256: depth in 32-bit words.
- `RAM_SIZE_BIT`, 8: log2(`RAM_SIZE`).
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0. Must be word-aligned.

- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `mem_read` in 1: load request this cycle.
- `mem_write` in 1: store request this cycle.
- `size` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `sign_ext` in 1: loads only. 1 = sign-extend, 0 = zero-extend.
- `address` in 32: byte address.
- `write_data` in 32: store data. The low 8/16/32 bits are used.
- `read_data` out 32: extended load result (combinational).
- `busy` out 1: clear sweep in progress; pipeline must stall.
- `fault` out 1: current access faults (combinational).
- `fault_cause` out 2: 01 = misaligned, 10 = out of range, 11 = reserved size, 00 = none (combinational).
- `fault_clear` in 1: clears the sticky fault record.
- `fault_valid` out 1: sticky; a fault has been recorded.
- `fault_addr` out 32: address of the recorded fault.

## Operation
- **Offset and word index.**
  - `off` = `address` − `BASE_ADDR`, 32-bit, wraps modulo 2^32.
  - Word index = `off[RAM_SIZE_BIT+1:2]`.
  - Byte lanes are little-endian: lane 0 = bits 7:0.
- **Access** = (`mem_read` | `mem_write`) & !`busy`. `fault` is evaluated only for an access; otherwise `fault` = 0 and `fault_cause` = 00.
- **Fault priority:** reserved size > out of range > misaligned.
  - Out of range: `off` ≥ 4·`RAM_SIZE`.
  - Misaligned: half with `off[0]` = 1, or word with `off[1:0]` ≠ 0.
- **Store (no fault):**
  - byte: writes lane `off[1:0]` with `write_data[7:0]`.
  - half: writes lanes {`off[1]`,0..1} with `write_data[15:0]`.
  - word: writes the full word.
  - Other lanes are preserved.
- **Faulted store:** memory is unchanged.
- **Load (no fault):** selects the lane(s) as for stores, then extends to 32 bits per `sign_ext`. Word loads ignore `sign_ext`.
- **Forced zero:** `read_data` = 0 when `mem_read` = 0, during `busy`, or on a faulted load.
- **Simultaneous `mem_read` and `mem_write`:** the store is performed and `read_data` shows the pre-edge contents.
- **Clear FSM, states CLEAR and READY.**
  - `reset` forces CLEAR with `ptr` = 0.
  - In CLEAR, each cycle writes zero to word `ptr` and increments `ptr`.
  - After writing word `RAM_SIZE`−1, the FSM moves to READY. `busy` = (state == CLEAR).
  - Reasserting `reset` mid-sweep restarts at `ptr` = 0.
- **Sticky fault record.**
  - On a clock edge with `fault` = 1 and `fault_valid` = 0: set `fault_valid` and capture `address` into `fault_addr`.
  - Later faults do not overwrite the record while `fault_valid` = 1.
  - `fault_clear` clears `fault_valid`.
  - If `fault_clear` and `fault` occur on the same edge, the new fault is recorded (set wins).

## Timing
- Reset values:
  - state = CLEAR, `busy` = 1, `ptr` = 0.
  - `fault_valid` = 0, `fault_addr` = 0.
  - `read_data` = 0, `fault` = 0.
- The sweep lasts exactly `RAM_SIZE` cycles after `reset` deasserts. `busy` falls at the edge that writes the last word.
- Stores take effect at the rising `clk` edge of the request cycle.
- Loads are zero-latency and combinational from the current memory contents. A load in the cycle after a store returns the new data.
- The sticky record updates at the rising edge. `fault` and `fault_cause` are valid in the same cycle as the request.

## Structure
- Shared package `mem_pkg`:
  - `size` codes: `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - `fault_cause` codes: `FC_NONE`, `FC_MISALIGN`, `FC_RANGE`, `FC_SIZE`.
  - FSM state constants.
- Sub-module `mem_lane_align` (combinational):
  - Store side: `size`, `off[1:0]`, `write_data` → 4-bit byte enable and replicated write word.
  - Load side: raw word, `size`, `off[1:0]`, `sign_ext` → extended `read_data`.
- The top level holds the RAM array, the clear FSM, fault decode and the sticky record.

## Test plan
- Reset, then check sweep: `busy` = 1 for exactly 256 cycles. A `sw` during `busy` to 0x10 is dropped; after READY, `lw` 0x10 returns 0.
- Byte/half stores and loads:
  - `sw` 0x20 = 0x11223344; `sb` 0x21 = 0xAB. `lw` 0x20 returns 0x1122AB44.
  - `lb` 0x21 returns 0xFFFFFFAB; `lbu` 0x21 returns 0x000000AB.
  - `sh` 0x22 = 0x8001. `lh` 0x22 returns 0xFFFF8001; `lhu` 0x22 returns 0x00008001.
- Misaligned store:
  - `sw` to 0x42 → `fault` = 1, `fault_cause` = 01, memory unchanged.
  - Next edge: `fault_valid` = 1, `fault_addr` = 0x42.
  - A later `lh` 0x43 does not change `fault_addr`.
- Out of range and priority:
  - `lw` 0x400 (RAM_SIZE 256) → `fault_cause` = 10, `read_data` = 0.
  - `size` = 11 at 0x401 → `fault_cause` = 11.
- Fault clear: `fault_clear` on the same edge as a new fault at 0x44 → `fault_valid` stays 1, `fault_addr` = 0x44. `fault_clear` alone → `fault_valid` = 0.
- Reset mid-sweep at cycle 100 → `busy` stays 1 for a further 256 cycles after deassertion. All words read 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the byte-enabled data memory: access sizes, fault causes
// and the clear-sweep FSM states.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_RANGE    = 2'b10,
        FC_SIZE     = 2'b11
    } fault_cause_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/data_memory_be_if.sv
// MEM-stage bus between the pipeline (master) and the data memory (slave).
interface data_memory_be_if;

    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        fault_clear;
    logic        fault_valid;
    logic [31:0] fault_addr;

    modport master (
        output mem_read, mem_write, size, sign_ext, address, write_data, fault_clear,
        input  read_data, busy, fault, fault_cause, fault_valid, fault_addr
    );

    modport slave (
        input  mem_read, mem_write, size, sign_ext, address, write_data, fault_clear,
        output read_data, busy, fault, fault_cause, fault_valid, fault_addr
    );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: store-side byte enables and replicated data,
// load-side lane extraction with sign/zero extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  off_lo,
    input  logic [31:0] write_data,
    input  logic [31:0] raw_word,
    input  logic        sign_ext,
    output logic [3:0]  byte_en,
    output logic [31:0] write_word,
    output logic [31:0] read_ext
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = raw_word[{off_lo, 3'b000} +: 8];
    assign ld_half = off_lo[1] ? raw_word[31:16] : raw_word[15:0];

    always_comb begin
        byte_en    = 4'b0000;
        write_word = write_data;
        case (size)
            SZ_BYTE: begin
                byte_en    = 4'b0001 << off_lo;
                write_word = {4{write_data[7:0]}};
            end
            SZ_HALF: begin
                byte_en    = off_lo[1] ? 4'b1100 : 4'b0011;
                write_word = {2{write_data[15:0]}};
            end
            SZ_WORD: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    always_comb begin
        read_ext = raw_word;
        case (size)
            SZ_BYTE: read_ext = {{24{sign_ext & ld_byte[7]}}, ld_byte};
            SZ_HALF: read_ext = {{16{sign_ext & ld_half[15]}}, ld_half};
            default: read_ext = raw_word;
        endcase
    end

endmodule

// File: rtl/data_memory_be.sv
// MEM-stage data memory with byte enables, a post-reset clear sweep that stalls
// the pipeline, and range/alignment fault detection with a sticky fault record.
module data_memory_be
    import mem_pkg::*;
#(
    parameter int          RAM_SIZE     = 256,
    parameter int          RAM_SIZE_BIT = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    data_memory_be_if.slave  bus
);

    localparam logic [31:0] BYTE_SPAN = 32'(RAM_SIZE) << 2;
    localparam logic [RAM_SIZE_BIT-1:0] LAST_IDX = RAM_SIZE_BIT'(RAM_SIZE - 1);

    logic [31:0] mem_q [RAM_SIZE];

    state_e                  state_q, state_d;
    logic [RAM_SIZE_BIT-1:0] ptr_q, ptr_d;
    logic                    fault_valid_q, fault_valid_d;
    logic [31:0]             fault_addr_q, fault_addr_d;

    logic [31:0]             off;
    logic [RAM_SIZE_BIT-1:0] idx;
    size_e                   sz;
    logic                    busy;
    logic                    access;
    fault_cause_e            cause;
    logic                    fault;

    logic [3:0]              st_be;
    logic [31:0]             st_word;
    logic [31:0]             ld_ext;

    logic                    ram_we;
    logic [RAM_SIZE_BIT-1:0] ram_idx;
    logic [3:0]              ram_be;
    logic [31:0]             ram_wdata;

    assign off    = bus.address - BASE_ADDR;
    assign idx    = off[RAM_SIZE_BIT+1:2];
    assign sz     = size_e'(bus.size);
    assign busy   = (state_q == ST_CLEAR);
    assign access = (bus.mem_read | bus.mem_write) & ~busy;

    // Reserved size outranks range, which outranks alignment.
    always_comb begin
        cause = FC_NONE;
        if (access) begin
            if (sz == SZ_RSVD)
                cause = FC_SIZE;
            else if (off >= BYTE_SPAN)
                cause = FC_RANGE;
            else if ((sz == SZ_HALF && off[0]) || (sz == SZ_WORD && off[1:0] != 2'b00))
                cause = FC_MISALIGN;
        end
    end

    assign fault = (cause != FC_NONE);

    mem_lane_align u_lane_align (
        .size       (sz),
        .off_lo     (off[1:0]),
        .write_data (bus.write_data),
        .raw_word   (mem_q[idx]),
        .sign_ext   (bus.sign_ext),
        .byte_en    (st_be),
        .write_word (st_word),
        .read_ext   (ld_ext)
    );

    // The clear sweep owns the write port; pipeline stores only land once READY.
    always_comb begin
        ram_we    = 1'b0;
        ram_idx   = idx;
        ram_be    = st_be;
        ram_wdata = st_word;
        if (busy) begin
            ram_we    = 1'b1;
            ram_idx   = ptr_q;
            ram_be    = 4'b1111;
            ram_wdata = '0;
        end else if (bus.mem_write && !fault) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b])
                    mem_q[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_IDX)
                    state_d = ST_READY;
            end
            default: state_d = ST_READY;
        endcase
    end

    // A clear on the same edge as a new fault still records the new fault.
    always_comb begin
        fault_valid_d = fault_valid_q;
        fault_addr_d  = fault_addr_q;
        if (bus.fault_clear)
            fault_valid_d = 1'b0;
        if (fault && (!fault_valid_q || bus.fault_clear)) begin
            fault_valid_d = 1'b1;
            fault_addr_d  = bus.address;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_CLEAR;
            ptr_q         <= '0;
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            fault_valid_q <= fault_valid_d;
            fault_addr_q  <= fault_addr_d;
        end
    end

    assign bus.read_data   = (bus.mem_read && !busy && !fault) ? ld_ext : '0;
    assign bus.busy        = busy;
    assign bus.fault       = fault;
    assign bus.fault_cause = cause;
    assign bus.fault_valid = fault_valid_q;
    assign bus.fault_addr  = fault_addr_q;

endmodule
